// File: rtl/tape_mem_arbiter_pkg.sv
// Shared types for the tape/aux SDRAM read arbiter: FSM encoding, client IDs
// and the round-robin pick.
package tape_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic CLI_TAPE = 1'b0;
  localparam logic CLI_AUX  = 1'b1;

  localparam int DEF_ADDR_W = 25;

  // On contention the client that did not win last time gets the grant.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    return req1 ? CLI_AUX : CLI_TAPE;
  endfunction

endpackage

// File: rtl/tape_mem_arbiter_if.sv
// Requester and SDRAM read-port signals of the arbiter, bundled as one interface.
interface tape_mem_arbiter_if
  import tape_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              c0_req;
  logic [ADDR_W-1:0] c0_addr;
  logic [7:0]        c0_data;
  logic              c0_valid;

  logic              c1_req;
  logic [ADDR_W-1:0] c1_addr;
  logic [7:0]        c1_data;
  logic              c1_valid;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  logic              busy;
  logic              grant_id;

  modport slave (
    input  c0_req, c0_addr, c1_req, c1_addr, mem_data,
    output c0_data, c0_valid, c1_data, c1_valid, mem_rd, mem_addr, busy, grant_id
  );

  modport master (
    output c0_req, c0_addr, c1_req, c1_addr, mem_data,
    input  c0_data, c0_valid, c1_data, c1_valid, mem_rd, mem_addr, busy, grant_id
  );

endinterface

// File: rtl/tape_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SDRAM byte-read port between
// the cassette engine (client 0) and a secondary loader (client 1).
//
// state | meaning
// IDLE  | sample requests, latch winner's address
// ISSUE | one-cycle mem_rd strobe, load latency counter
// WAIT  | count down read latency, capture mem_data at count 1
// DONE  | one-cycle valid pulse to the granted client
module tape_mem_arbiter
  import tape_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  tape_mem_arbiter_if.slave  bus
);

  localparam logic [3:0] LAT_CNT = 4'(RD_LAT);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              last_grant, last_grant_n;
  logic              grant_q, grant_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [7:0]        data0, data0_n;
  logic [7:0]        data1, data1_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= CLI_AUX;
      grant_q    <= CLI_TAPE;
      addr_q     <= '0;
      data0      <= '0;
      data1      <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_grant <= last_grant_n;
      grant_q    <= grant_n;
      addr_q     <= addr_n;
      data0      <= data0_n;
      data1      <= data1_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_grant_n = last_grant;
    grant_n      = grant_q;
    addr_n       = addr_q;
    data0_n      = data0;
    data1_n      = data1;

    unique case (state)
      IDLE: begin
        if (bus.c0_req || bus.c1_req) begin
          grant_n      = rr_pick(bus.c0_req, bus.c1_req, last_grant);
          last_grant_n = grant_n;
          addr_n       = (grant_n == CLI_TAPE) ? bus.c0_addr : bus.c1_addr;
          state_n      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = LAT_CNT;
        state_n = WAIT;
      end
      WAIT: begin
        // Count 1 marks the cycle mem_data is valid for this read.
        if (cnt == 4'd1) begin
          if (grant_q == CLI_TAPE) data0_n = bus.mem_data;
          else                     data1_n = bus.mem_data;
          state_n = DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.mem_rd   = (state == ISSUE);
  assign bus.mem_addr = addr_q;
  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = grant_q;
  assign bus.c0_data  = data0;
  assign bus.c1_data  = data1;
  assign bus.c0_valid = (state == DONE) && (grant_q == CLI_TAPE);
  assign bus.c1_valid = (state == DONE) && (grant_q == CLI_AUX);

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Directed bench for tape_mem_arbiter: transaction-level model checked every
// cycle, plus literal timing/data expectations for each scenario.
module tb_tape_mem_arbiter;
  import tape_pkg::*;

  localparam int AW  = 25;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  tape_mem_arbiter_if #(.ADDR_W(AW)) bus ();
  tape_mem_arbiter #(.ADDR_W(AW), .RD_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  tape_mem_arbiter_if #(.ADDR_W(AW)) bus1 ();
  tape_mem_arbiter #(.ADDR_W(AW), .RD_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    case (a)
      25'h10:  return 8'hA5;
      25'h50:  return 8'h3C;
      25'h60:  return 8'hC3;
      default: return a[7:0] ^ a[15:8] ^ 8'h96;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // SDRAM models: data appears only in the cycle it is due, junk otherwise
  typedef struct {int due; logic [AW-1:0] addr;} rd_t;
  rd_t pend[$];
  rd_t pend1[$];

  always @(negedge clk) begin
    bus.mem_data = 8'hEE;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      bus.mem_data = mem_byte(pend[0].addr);
      void'(pend.pop_front());
    end
    if (bus.mem_rd) pend.push_back('{cyc + LAT, bus.mem_addr});

    bus1.mem_data = 8'hEE;
    if (pend1.size() > 0 && pend1[0].due == cyc) begin
      bus1.mem_data = mem_byte(pend1[0].addr);
      void'(pend1.pop_front());
    end
    if (bus1.mem_rd) pend1.push_back('{cyc + 1, bus1.mem_addr});
  end

  // Event log of strobes for literal checks
  int          rd_log[$];
  logic [AW-1:0] a_log[$];
  logic        g_log[$];
  always @(negedge clk) begin
    if (bus.mem_rd) begin
      rd_log.push_back(cyc);
      a_log.push_back(bus.mem_addr);
      g_log.push_back(bus.grant_id);
    end
  end

  // Transaction-level reference: a grant at cycle T yields strobe at T+1,
  // valid at T+2+LAT and the next arbitration at T+3+LAT.
  int            rd_cyc = -1, val_cyc = -1, next_arb = 0;
  logic          sg, last_m;
  logic [AW-1:0] sa, e_addr;
  logic [7:0]    sd, e_d0, e_d1;
  logic          e_grant;
  bit            live = 0, rst_pend = 0;

  always @(negedge clk) begin
    if (rst_pend) begin
      e_addr = '0; e_grant = 1'b0; e_d0 = 8'h00; e_d1 = 8'h00; last_m = 1'b1;
      live = 1; rst_pend = 0;
    end
    if (cyc == rd_cyc) begin e_addr = sa; e_grant = sg; end
    if (cyc == val_cyc) begin
      if (sg) e_d1 = sd;
      else    e_d0 = sd;
    end
    if (live) begin
      chk("mem_rd",   bus.mem_rd,   cyc == rd_cyc);
      chk("busy",     bus.busy,     rd_cyc >= 0 && cyc >= rd_cyc && cyc <= val_cyc);
      chk("c0_valid", bus.c0_valid, cyc == val_cyc && !sg);
      chk("c1_valid", bus.c1_valid, cyc == val_cyc && sg);
      chk("grant_id", bus.grant_id, e_grant);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("c0_data",  bus.c0_data,  e_d0);
      chk("c1_data",  bus.c1_data,  e_d1);
    end
    if (reset) begin
      rst_pend = 1; next_arb = cyc + 1; rd_cyc = -1; val_cyc = -1;
    end else if (live && cyc == next_arb) begin
      if (bus.c0_req || bus.c1_req) begin
        sg = (bus.c0_req && bus.c1_req) ? !last_m : bus.c1_req;
        last_m = sg;
        sa = sg ? bus.c1_addr : bus.c0_addr;
        sd = mem_byte(sa);
        rd_cyc = cyc + 1; val_cyc = cyc + 2 + LAT; next_arb = cyc + 3 + LAT;
      end else begin
        next_arb = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int sel, output int vc);
    bit found = 0;
    vc = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if ((sel == 0 && bus.c0_valid) || (sel == 1 && bus.c1_valid) ||
          (sel == 2 && bus1.c0_valid)) begin
        found = 1;
        vc = cyc;
      end
    end
    if (!found) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #30000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    int t, vc, vc2, n0, n1, seen;
    bit p0, p1;
    logic [AW-1:0] exp_a[6];
    exp_a = '{25'h300, 25'h400, 25'h301, 25'h401, 25'h302, 25'h402};

    reset = 1'b1;
    bus.c0_req = 0; bus.c1_req = 0; bus.c0_addr = '0; bus.c1_addr = '0;
    bus1.c0_req = 0; bus1.c1_req = 0; bus1.c0_addr = '0; bus1.c1_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant_id, 0);

    // single client 0 read
    rd_log.delete(); a_log.delete(); g_log.delete();
    bus.c0_addr = 25'h10; bus.c0_req = 1; t = cyc;
    wait_valid(0, vc);
    chk("t1_valid_cyc", vc, t + 4);
    chk("t1_c0_data", bus.c0_data, 8'hA5);
    chk("t1_c1_data", bus.c1_data, 8'h00);
    chk("t1_rd_count", rd_log.size(), 1);
    chk("t1_rd_cyc", rd_log[0], t + 1);
    chk("t1_rd_addr", a_log[0], 25'h10);
    tick(); bus.c0_req = 0;

    // simultaneous requests after reset: client 0 first
    reset = 1; tick(); reset = 0;
    rd_log.delete(); a_log.delete(); g_log.delete();
    bus.c0_addr = 25'h100; bus.c1_addr = 25'h200;
    bus.c0_req = 1; bus.c1_req = 1; t = cyc;
    wait_valid(0, vc);
    chk("t2_c0_valid_cyc", vc, t + 4);
    tick(); bus.c0_req = 0;
    wait_valid(1, vc2);
    chk("t2_c1_valid_cyc", vc2, t + 9);
    chk("t2_rd2_cyc", rd_log[1], t + 6);
    chk("t2_rd2_addr", a_log[1], 25'h200);
    chk("t2_c1_data", bus.c1_data, 8'h94);
    tick();

    // continuous contention, 6 transactions
    rd_log.delete(); a_log.delete(); g_log.delete();
    bus.c0_addr = 25'h300; bus.c1_addr = 25'h400; bus.c0_req = 1; bus.c1_req = 1;
    n0 = 0; n1 = 0; p0 = 0; p1 = 0;
    for (int i = 0; i < 100 && (n0 < 3 || n1 < 3); i++) begin
      tick();
      if (p0) begin p0 = 0; if (n0 < 3) bus.c0_addr = bus.c0_addr + 1; else bus.c0_req = 0; end
      if (p1) begin p1 = 0; if (n1 < 3) bus.c1_addr = bus.c1_addr + 1; else bus.c1_req = 0; end
      if (bus.c0_valid) begin n0++; p0 = 1; end
      if (bus.c1_valid) begin n1++; p1 = 1; end
    end
    tick(); bus.c0_req = 0; bus.c1_req = 0;
    chk("t3_n0", n0, 3);
    chk("t3_n1", n1, 3);
    chk("t3_rd_count", rd_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t3_grant_seq", g_log[i], i % 2);
      chk("t3_addr_seq", a_log[i], exp_a[i]);
      if (i > 0) chk("t3_rd_spacing", rd_log[i] - rd_log[i-1], LAT + 3);
    end
    tick();

    // reset during WAIT of a client 1 read
    bus.c1_addr = 25'h500; bus.c1_req = 1; t = cyc;
    tick(); tick();
    reset = 1; bus.c1_req = 0;
    tick(); reset = 0;
    chk("t4_busy", bus.busy, 0);
    chk("t4_mem_rd", bus.mem_rd, 0);
    chk("t4_c1_data", bus.c1_data, 8'h00);
    seen = 0;
    repeat (10) begin tick(); if (bus.c1_valid) seen++; end
    chk("t4_no_valid", seen, 0);
    bus.c1_addr = 25'h520; bus.c1_req = 1; t = cyc;
    wait_valid(1, vc);
    chk("t4_fresh_cyc", vc, t + 4);
    chk("t4_fresh_data", bus.c1_data, 8'hB3);
    tick(); bus.c1_req = 0;

    // address change mid-transaction, then back-to-back
    bus.c0_addr = 25'h50; bus.c0_req = 1; t = cyc;
    tick(); tick();
    bus.c0_addr = 25'h60;
    wait_valid(0, vc);
    chk("t5_valid1_cyc", vc, t + 4);
    chk("t5_data1", bus.c0_data, 8'h3C);
    wait_valid(0, vc2);
    chk("t5_valid2_cyc", vc2, t + 9);
    chk("t5_data2", bus.c0_data, 8'hC3);
    tick(); bus.c0_req = 0;

    // RD_LAT=1 instance
    bus1.c0_addr = 25'h77; bus1.c0_req = 1; t = cyc;
    wait_valid(2, vc);
    chk("t6_valid_cyc", vc, t + 3);
    chk("t6_data", bus1.c0_data, 8'hE1);
    chk("t6_c1_data", bus1.c1_data, 8'h00);
    tick(); bus1.c0_req = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
